// File: rtl/knn_pkg.sv
// Shared constants and types for the KNN classifier pipeline.
// The default class count, the largest K and the widths derived from them
// are shared by the distance sorter and the vote accumulator.
package knn_pkg;

    localparam int NUM_CLASSES_DEF = 4;
    localparam int K_MAX_DEF       = 7;
    localparam int CLASS_W_DEF     = $clog2(NUM_CLASSES_DEF);
    localparam int CNT_W_DEF       = $clog2(K_MAX_DEF + 1);

    // Vote accumulator control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } vote_state_t;

endpackage

// File: rtl/knn_vote_accum_if.sv
// Bundle for the vote accumulator: run-time K select, abort, the label
// input stream and the predicted-class output stream.
// master = label producer / result consumer, slave = the accumulator.
interface knn_vote_accum_if
    import knn_pkg::*;
#(
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) ();

    logic [CNT_W-1:0]   k_sel;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] in_class;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic [CNT_W-1:0]   out_count;
    logic               out_bad;

    modport master (
        output k_sel, abort, in_valid, in_class, out_ready,
        input  in_ready, out_valid, out_class, out_count, out_bad
    );

    modport slave (
        input  k_sel, abort, in_valid, in_class, out_ready,
        output in_ready, out_valid, out_class, out_count, out_bad
    );

endinterface

// File: rtl/knn_vote_counter_bank.sv
// Per-class vote counters for the KNN voter, with a read port addressed by
// the argmax scan index. With TIE_FIRST_EN defined each class also keeps
// the vote index of its first vote so ties can go to the nearest neighbour.
module knn_vote_counter_bank
    import knn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int CLASS_W     = $clog2(NUM_CLASSES),
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               inc_en,
    input  logic [CLASS_W-1:0] inc_class,
`ifdef TIE_FIRST_EN
    input  logic [CNT_W-1:0]   vote_idx,
    output logic [CNT_W-1:0]   rd_first,
`endif
    input  logic [CLASS_W-1:0] rd_idx,
    output logic [CNT_W-1:0]   rd_cnt
);

    logic [CNT_W-1:0] cnt [NUM_CLASSES];

    // Count one vote for the addressed class; clear wipes every counter
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (!rst_n || clear) begin
                cnt[c] <= '0;
            end else if (inc_en && (inc_class == CLASS_W'(c))) begin
                cnt[c] <= cnt[c] + CNT_W'(1);
            end
        end
    end

    // Read mux feeding the argmax scan
    always_comb begin
        rd_cnt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (rd_idx == CLASS_W'(c)) begin
                rd_cnt = cnt[c];
            end
        end
    end

`ifdef TIE_FIRST_EN
    logic [CNT_W-1:0] first_idx [NUM_CLASSES];

    // Remember when each class received its first vote
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (!rst_n || clear) begin
                first_idx[c] <= '0;
            end else if (inc_en && (inc_class == CLASS_W'(c)) && (cnt[c] == '0)) begin
                first_idx[c] <= vote_idx;
            end
        end
    end

    // First-vote index of the class under scan
    always_comb begin
        rd_first = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (rd_idx == CLASS_W'(c)) begin
                rd_first = first_idx[c];
            end
        end
    end
`endif

endmodule

// File: rtl/knn_vote_accum.sv
// Streaming K-nearest-neighbour majority voter.
// Takes one neighbour label per cycle (nearest first), counts K of them,
// then scans the class counters one per cycle to find the winner and
// presents it on a valid/ready output.
// Optional macro TIE_FIRST_EN: on equal counts the class whose first vote
// arrived earliest wins; otherwise the lowest class index wins.
module knn_vote_accum
    import knn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int CLASS_W     = $clog2(NUM_CLASSES),
    parameter int K_MAX       = K_MAX_DEF,
    parameter int CNT_W       = $clog2(K_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    knn_vote_accum_if.slave bus
);

    localparam logic [CNT_W-1:0]   K_MAX_L       = CNT_W'(K_MAX);
    localparam logic [CNT_W-1:0]   K_ONE         = CNT_W'(1);
    localparam logic [CLASS_W:0]   NUM_CLASSES_L = (CLASS_W + 1)'(NUM_CLASSES);
    localparam logic [CLASS_W-1:0] LAST_IDX      = CLASS_W'(NUM_CLASSES - 1);

    vote_state_t        state;
    vote_state_t        state_next;

    logic [CNT_W-1:0]   k_eff;
    logic [CNT_W-1:0]   k_clamped;
    logic [CNT_W-1:0]   vote_idx;
    logic [CNT_W-1:0]   vote_idx_inc;
    logic               bad_flag;

    logic [CLASS_W-1:0] scan_idx;
    logic [CLASS_W-1:0] best_class;
    logic [CNT_W-1:0]   best_cnt;
    logic [CLASS_W-1:0] cand_class;
    logic [CNT_W-1:0]   cand_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic               take_candidate;

    logic               out_valid_q;
    logic [CLASS_W-1:0] out_class_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_bad_q;

    logic               in_ready_int;
    logic               accept;
    logic               label_ok;
    logic               out_take;
    logic               bank_clear;
    logic               scan_last;

`ifdef TIE_FIRST_EN
    logic [CNT_W-1:0]   rd_first;
    logic [CNT_W-1:0]   best_first;
    logic [CNT_W-1:0]   cand_first;
`endif

    assign in_ready_int = rst_n && !bus.abort &&
                          ((state == ST_IDLE) || (state == ST_COLLECT));
    assign accept       = bus.in_valid && in_ready_int;
    assign label_ok     = ({1'b0, bus.in_class} < NUM_CLASSES_L);
    assign vote_idx_inc = vote_idx + K_ONE;
    assign out_take     = (state == ST_DONE) && out_valid_q && bus.out_ready;
    assign bank_clear   = bus.abort || out_take;
    assign scan_last    = (scan_idx == LAST_IDX);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_count = out_count_q;
    assign bus.out_bad   = out_bad_q;

    // K of zero means one vote; anything above K_MAX saturates
    always_comb begin
        k_clamped = bus.k_sel;
        if (bus.k_sel == '0) begin
            k_clamped = K_ONE;
        end else if (bus.k_sel > K_MAX_L) begin
            k_clamped = K_MAX_L;
        end
    end

    knn_vote_counter_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLASS_W     (CLASS_W),
        .CNT_W       (CNT_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bank_clear),
        .inc_en    (accept && label_ok),
        .inc_class (bus.in_class),
`ifdef TIE_FIRST_EN
        .vote_idx  (vote_idx),
        .rd_first  (rd_first),
`endif
        .rd_idx    (scan_idx),
        .rd_cnt    (rd_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides any vote or output handshake
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (k_clamped == K_ONE) ? ST_SCAN : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && (vote_idx_inc == k_eff)) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_take) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_next = ST_IDLE;
        end
    end

    // Argmax step: a strictly larger count displaces the current best
    always_comb begin
        take_candidate = (rd_cnt > best_cnt);
`ifdef TIE_FIRST_EN
        if ((rd_cnt == best_cnt) && (rd_cnt != '0) && (rd_first < best_first)) begin
            take_candidate = 1'b1;
        end
        cand_first = take_candidate ? rd_first : best_first;
`endif
        cand_class = take_candidate ? scan_idx : best_class;
        cand_cnt   = take_candidate ? rd_cnt   : best_cnt;
    end

    // Vote bookkeeping, scan registers and the held output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_eff       <= '0;
            vote_idx    <= '0;
            bad_flag    <= 1'b0;
            scan_idx    <= '0;
            best_class  <= '0;
            best_cnt    <= '0;
`ifdef TIE_FIRST_EN
            best_first  <= '0;
`endif
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_bad_q   <= 1'b0;
        end else if (bus.abort) begin
            vote_idx    <= '0;
            bad_flag    <= 1'b0;
            scan_idx    <= '0;
            best_class  <= '0;
            best_cnt    <= '0;
`ifdef TIE_FIRST_EN
            best_first  <= '0;
`endif
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                if (state == ST_IDLE) begin
                    k_eff <= k_clamped;
                end
                vote_idx <= vote_idx_inc;
                if (!label_ok) begin
                    bad_flag <= 1'b1;
                end
            end

            if (state == ST_SCAN) begin
                best_class <= cand_class;
                best_cnt   <= cand_cnt;
`ifdef TIE_FIRST_EN
                best_first <= cand_first;
`endif
                if (scan_last) begin
                    scan_idx    <= '0;
                    out_valid_q <= 1'b1;
                    out_class_q <= cand_class;
                    out_count_q <= cand_cnt;
                    out_bad_q   <= bad_flag;
                end else begin
                    scan_idx <= scan_idx + CLASS_W'(1);
                end
            end else begin
                scan_idx   <= '0;
                best_class <= '0;
                best_cnt   <= '0;
`ifdef TIE_FIRST_EN
                best_first <= '0;
`endif
            end

            if (out_take) begin
                out_valid_q <= 1'b0;
                vote_idx    <= '0;
                bad_flag    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_knn_vote_accum.sv
// Scoreboard bench for knn_vote_accum, built with 5 classes and K_MAX=5 so
// labels 5..7 exercise the bad-label path and k_sel 6..7 exercise clamping.
// Works with or without TIE_FIRST_EN; the reference model follows the macro.
module tb_knn_vote_accum;

    localparam int NUM_CLASSES = 5;
    localparam int K_MAX       = 5;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    localparam int CNT_W       = $clog2(K_MAX + 1);

    typedef struct {
        int cls;
        int cnt;
        int bad;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    knn_vote_accum_if #(.CLASS_W(CLASS_W), .CNT_W(CNT_W)) bus ();

    knn_vote_accum #(
        .NUM_CLASSES (NUM_CLASSES),
        .CLASS_W     (CLASS_W),
        .K_MAX       (K_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    int   last_accept_cycle = 0;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;
    int   lab_buf [8];
    exp_t exp_q [$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count the first K labels, then pick the majority class
    function automatic exp_t model(input int k);
        exp_t r;
        int   keff;
        int   cnt   [NUM_CLASSES];
        int   first [NUM_CLASSES];
        int   m;
        int   bestf;
        keff = (k < 1) ? 1 : ((k > K_MAX) ? K_MAX : k);
        r.bad = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt[c]   = 0;
            first[c] = 99;
        end
        for (int i = 0; i < keff; i++) begin
            if (lab_buf[i] >= NUM_CLASSES) begin
                r.bad = 1;
            end else begin
                if (cnt[lab_buf[i]] == 0) first[lab_buf[i]] = i;
                cnt[lab_buf[i]]++;
            end
        end
        m = 0;
        for (int c = 0; c < NUM_CLASSES; c++) if (cnt[c] > m) m = cnt[c];
        r.cnt = m;
        r.cls = 0;
        if (m > 0) begin
`ifdef TIE_FIRST_EN
            bestf = 99;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (cnt[c] == m && first[c] < bestf) begin
                    bestf = first[c];
                    r.cls = c;
                end
            end
`else
            bestf = 0;
            for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
                if (cnt[c] == m) r.cls = c;
            end
`endif
        end
        return r;
    endfunction

    // Monitor: compare the presented result with the scoreboard head
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_valid = 1'b0;
        end else if (bus.out_valid === 1'b1) begin
            if (!prev_valid) checkOutput("latency", cycle - last_accept_cycle, NUM_CLASSES);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                checkOutput("out_class", int'(bus.out_class), exp_q[0].cls);
                checkOutput("out_count", int'(bus.out_count), exp_q[0].cnt);
                checkOutput("out_bad",   int'(bus.out_bad),   exp_q[0].bad);
                checkOutput("in_ready_busy", int'(bus.in_ready), 0);
                if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Feed n labels from lab_buf; push the model result when requested
    task automatic applyStimulus(input int k, input int n, input bit push_exp, input bit gaps);
        int  w;
        bit  acc;
        if (push_exp) exp_q.push_back(model(k));
        bus.k_sel = CNT_W'(k);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_class = CLASS_W'(lab_buf[i]);
            acc = 1'b0;
            w   = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (bus.in_ready === 1'b1);
                tick();
                if (!acc) begin
                    w++;
                    if (w > 200) begin
                        checkOutput("accept_timeout", 0, 1);
                        bus.in_valid = 1'b0;
                        return;
                    end
                end
            end
            last_accept_cycle = cycle;
            bus.k_sel = CNT_W'($urandom_range(0, 7));
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        if (push_exp) begin
            @(negedge clk);
            checkOutput("in_ready_after_last_vote", int'(bus.in_ready), 0);
            tick();
        end
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 400) begin
            tick();
            w++;
        end
        if (exp_q.size() > 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        int k;
        int w;
        rst_n        = 1'b0;
        bus.k_sel    = '0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_class = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_in_ready",  int'(bus.in_ready),  0);
        checkOutput("reset_out_class", int'(bus.out_class), 0);
        checkOutput("reset_out_count", int'(bus.out_count), 0);
        checkOutput("reset_out_bad",   int'(bus.out_bad),   0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", int'(bus.in_ready), 1);
        tick();

        // Directed runs
        lab_buf[0] = 2; lab_buf[1] = 1; lab_buf[2] = 2;
        applyStimulus(3, 3, 1'b1, 1'b0);
        waitDrain();
        lab_buf[0] = 3; lab_buf[1] = 1; lab_buf[2] = 1; lab_buf[3] = 3;
        applyStimulus(4, 4, 1'b1, 1'b0);
        waitDrain();
        lab_buf[0] = 0; lab_buf[1] = 6; lab_buf[2] = 1; lab_buf[3] = 1; lab_buf[4] = 1;
        applyStimulus(5, 5, 1'b1, 1'b0);
        waitDrain();
        lab_buf[0] = 2;
        applyStimulus(0, 1, 1'b1, 1'b0);
        waitDrain();
        lab_buf[0] = 4; lab_buf[1] = 0; lab_buf[2] = 4; lab_buf[3] = 3; lab_buf[4] = 0;
        applyStimulus(7, K_MAX, 1'b1, 1'b0);
        waitDrain();

        // Back-pressure: result held for 10 cycles, then released
        $display("[TB] back-pressure run");
        bus.out_ready = 1'b0;
        lab_buf[0] = 4; lab_buf[1] = 4; lab_buf[2] = 0;
        applyStimulus(3, 3, 1'b1, 1'b0);
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        checkOutput("bp_valid_seen", int'(bus.out_valid === 1'b1), 1);
        repeat (10) tick();
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("bp_valid_drop", int'(bus.out_valid), 0);
        checkOutput("bp_ready_after_handshake", int'(bus.in_ready), 1);
        tick();
        checkOutput("bp_scoreboard_empty", exp_q.size(), 0);

        // Abort after two votes, then a clean run
        $display("[TB] abort run");
        lab_buf[0] = 1; lab_buf[1] = 1;
        applyStimulus(3, 2, 1'b0, 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready", int'(bus.in_ready), 0);
        tick();
        bus.abort = 1'b0;
        lab_buf[0] = 1; lab_buf[1] = 1; lab_buf[2] = 0;
        applyStimulus(3, 3, 1'b1, 1'b0);
        waitDrain();

        // Reset in the middle of the scan
        $display("[TB] reset during scan");
        lab_buf[0] = 3;
        applyStimulus(1, 1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("scan_reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("scan_reset_in_ready",  int'(bus.in_ready),  0);
        repeat (NUM_CLASSES + 2) tick();
        rst_n = 1'b1;
        tick();
        lab_buf[0] = 4;
        applyStimulus(1, 1, 1'b1, 1'b0);
        waitDrain();

        // Randomized runs with random back-pressure and input gaps
        $display("[TB] random runs");
        rand_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(0, 7);
            for (int i = 0; i < 8; i++) begin
                lab_buf[i] = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NUM_CLASSES - 1)
                                                        : $urandom_range(NUM_CLASSES, 7);
            end
            applyStimulus(k, (k < 1) ? 1 : ((k > K_MAX) ? K_MAX : k), 1'b1, 1'b1);
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("final_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
